// File: rtl/if_fetch_pkg.sv
// Shared types, IF state encodings and defaults for the instruction-fetch stage.
package if_fetch_pkg;

   typedef logic [31:0] InstAddrBus;
   typedef logic [31:0] InstBus;

   localparam InstBus     ZeroWord         = 32'h0000_0000;
   localparam InstAddrBus DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IF_IDLE = 2'd0,
      IF_RD   = 2'd1,
      IF_HOLD = 2'd2
   } if_state_e;

endpackage

// File: rtl/if_icache.sv
// Direct-mapped, one-word-per-line instruction cache; only built when IF_ICACHE_EN is defined.
module if_icache
   import if_fetch_pkg::*;
#(
   parameter int LINES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:2] rd_pc_i,
   output logic        hit_o,
   output InstBus      data_o,
   input  logic        wr_en_i,
   input  logic [31:2] wr_pc_i,
   input  InstBus      wr_data_i
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - IDX_W;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   InstBus           data_q [LINES];

   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0] rd_tag, wr_tag;

   assign rd_idx = rd_pc_i[IDX_W+1:2];
   assign rd_tag = rd_pc_i[31:IDX_W+2];
   assign wr_idx = wr_pc_i[IDX_W+1:2];
   assign wr_tag = wr_pc_i[31:IDX_W+2];

   assign hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign data_o = data_q[rd_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   // Tag/data storage needs no reset: a line is only read once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_idx]  <= wr_tag;
         data_q[wr_idx] <= wr_data_i;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit words from a byte-wide 1-cycle RAM port.
// Optional instruction cache enabled with the IF_ICACHE_EN macro.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter InstAddrBus RESET_PC     = DEFAULT_RESET_PC,
   parameter int         ICACHE_LINES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy_i,
   input  logic        mem_grant_i,
   input  logic [7:0]  mem_din_i,
   output logic [31:0] mem_a_o,
   output logic        mem_rd_o,
   input  logic        jump_i,
   input  logic [31:0] jump_addr_i,
   input  logic        id_ready_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
);

   if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_chk
      $error("ICACHE_LINES must be a power of two >= 2");
   end

   if_state_e  state_q, state_d;
   InstAddrBus pc_q, pc_d;
   logic [2:0] issue_cnt_q, issue_cnt_d;
   logic [2:0] recv_cnt_q, recv_cnt_d;
   InstBus     buf_q, buf_d;
   InstAddrBus pc_out_q, pc_out_d;
   InstBus     inst_q, inst_d;
   logic       valid_q, valid_d;
   logic       inflight_q;
   InstAddrBus mem_a_q;

   logic       issue, done, cache_hit;
   InstAddrBus issue_addr;
   InstBus     assembled, cache_data;

   // Byte 3 may arrive this cycle or may have been parked while rdy_i was low.
   assign assembled = (inflight_q && recv_cnt_q == 3'd3) ? {mem_din_i, buf_q[23:0]} : buf_q;
   assign done      = !jump_i && rdy_i && (state_q == IF_RD) &&
                      ((inflight_q && recv_cnt_q == 3'd3) || recv_cnt_q == 3'd4);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      buf_d       = buf_q;
      pc_out_d    = pc_out_q;
      inst_d      = inst_q;
      valid_d     = valid_q;
      issue       = 1'b0;
      issue_addr  = pc_q + {29'b0, issue_cnt_q};
      if (jump_i) begin
         pc_d        = jump_addr_i & 32'hFFFF_FFFC;
         issue_cnt_d = '0;
         recv_cnt_d  = '0;
         valid_d     = 1'b0;
         state_d     = IF_IDLE;
      end else begin
         if (inflight_q) begin
            buf_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_din_i;
            recv_cnt_d = recv_cnt_q + 3'd1;
         end
         case (state_q)
            IF_IDLE: begin
               if (rdy_i && cache_hit) begin
                  pc_out_d = pc_q;
                  inst_d   = cache_data;
                  valid_d  = 1'b1;
                  pc_d     = pc_q + 32'd4;
                  state_d  = IF_HOLD;
               end else if (rdy_i && mem_grant_i) begin
                  issue       = 1'b1;
                  issue_cnt_d = 3'd1;
                  state_d     = IF_RD;
               end
            end
            IF_RD: begin
               if (rdy_i && mem_grant_i && issue_cnt_q < 3'd4) begin
                  issue       = 1'b1;
                  issue_cnt_d = issue_cnt_q + 3'd1;
               end
               if (done) begin
                  pc_out_d    = pc_q;
                  inst_d      = assembled;
                  valid_d     = 1'b1;
                  pc_d        = pc_q + 32'd4;
                  issue_cnt_d = '0;
                  recv_cnt_d  = '0;
                  state_d     = IF_HOLD;
               end
            end
            IF_HOLD: begin
               if (rdy_i && id_ready_i) begin
                  valid_d = 1'b0;
                  state_d = IF_IDLE;
               end
            end
            default: state_d = IF_IDLE;
         endcase
      end
   end

   // No read strobe while reset is asserted, whatever rdy_i/mem_grant_i say.
   assign mem_rd_o = issue && rst;
   assign mem_a_o  = mem_rd_o ? issue_addr : mem_a_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IF_IDLE;
         pc_q        <= RESET_PC;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         inflight_q  <= 1'b0;
         mem_a_q     <= '0;
         pc_out_q    <= '0;
         inst_q      <= ZeroWord;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
         inflight_q  <= mem_rd_o;
         mem_a_q     <= mem_a_o;
         pc_out_q    <= pc_out_d;
         inst_q      <= inst_d;
         valid_q     <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign pc_o         = pc_out_q;
   assign inst_o       = inst_q;
   assign inst_valid_o = valid_q;

`ifdef IF_ICACHE_EN
   // A redirect forces done low, so an aborted fill never writes a line.
   if_icache #(.LINES(ICACHE_LINES)) u_icache (
      .clk       (clk),
      .rst       (rst),
      .rd_pc_i   (pc_q[31:2]),
      .hit_o     (cache_hit),
      .data_o    (cache_data),
      .wr_en_i   (done),
      .wr_pc_i   (pc_q[31:2]),
      .wr_data_i (assembled)
   );
`else
   assign cache_hit  = 1'b0;
   assign cache_data = ZeroWord;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle tables, directed corner sequences and a randomized stream check.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy_i = 1'b0, mem_grant_i = 1'b0, jump_i = 1'b0, id_ready_i = 1'b0;
   logic [7:0]  mem_din_i = 8'h00;
   logic [31:0] jump_addr_i = 32'h0;
   logic [31:0] mem_a_o, pc_o, inst_o;
   logic        mem_rd_o, inst_valid_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] ram_ov [logic [31:0]];

   if_fetch dut (
      .clk(clk), .rst(rst), .rdy_i(rdy_i), .mem_grant_i(mem_grant_i), .mem_din_i(mem_din_i),
      .mem_a_o(mem_a_o), .mem_rd_o(mem_rd_o), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
      .id_ready_i(id_ready_i), .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      logic [7:0] t;
      if (ram_ov.exists(a)) return ram_ov[a];
      t = a[7:0] * 8'd37;
      return t ^ a[15:8] ^ a[31:24];
   endfunction

   function automatic logic [31:0] ram_word(input logic [31:0] a);
      return {ram_byte(a + 32'd3), ram_byte(a + 32'd2), ram_byte(a + 32'd1), ram_byte(a)};
   endfunction

   // RAM: one-cycle read latency; garbage on the bus when no read was issued.
   always @(posedge clk) begin
      if (mem_rd_o) mem_din_i <= ram_byte(mem_a_o);
      else          mem_din_i <= 8'($urandom);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic r, input logic g, input logic idr, input logic j,
                      input logic [31:0] ja);
      @(negedge clk);
      rst = 1'b1; rdy_i = r; mem_grant_i = g; id_ready_i = idr; jump_i = j; jump_addr_i = ja;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; rdy_i = 1'b1; mem_grant_i = 1'b1; id_ready_i = 1'b0; jump_i = 1'b0;
      #1;
      chk("rst_mem_rd", {31'b0, mem_rd_o}, 32'd0);
      chk("rst_mem_a", mem_a_o, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      bit          rs;
      logic        rdy, gnt, idr;
      logic        erd;
      logic [31:0] ea;
      logic        ev;
      logic [31:0] epc, einst;
   } vec_t;

   function automatic vec_t mk(bit rs, logic rdy, logic gnt, logic idr, logic erd,
                               logic [31:0] ea, logic ev, logic [31:0] epc, logic [31:0] einst);
      vec_t v;
      v.rs = rs; v.rdy = rdy; v.gnt = gnt; v.idr = idr; v.erd = erd;
      v.ea = ea; v.ev = ev; v.epc = epc; v.einst = einst;
      return v;
   endfunction

   localparam logic [31:0] W0 = 32'h00A0_0513;
   localparam logic [31:0] W1 = 32'h0010_0593;

   vec_t vt[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r, g, idr, j, prev_v;
      logic [31:0] ja, exp_pc, hpc, hinst;
      int          since, delivered;

      ram_ov[32'h0] = 8'h13; ram_ov[32'h1] = 8'h05; ram_ov[32'h2] = 8'hA0; ram_ov[32'h3] = 8'h00;
      ram_ov[32'h4] = 8'h93; ram_ov[32'h5] = 8'h05; ram_ov[32'h6] = 8'h10; ram_ov[32'h7] = 8'h00;
      ram_ov[32'h1000] = 8'hEF; ram_ov[32'h1001] = 8'hBE;
      ram_ov[32'h1002] = 8'hAD; ram_ov[32'h1003] = 8'hDE;

      // Reset fetch, 10-cycle hold with id_ready low, then the next word at 4.
      vt.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 1, 2, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 1, 3, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 0, 3, 0, 0, 0));
      for (int k = 0; k < 10; k++) vt.push_back(mk(0, 1, 1, 0, 0, 3, 1, 0, W0));
      vt.push_back(mk(0, 1, 1, 1, 0, 3, 1, 0, W0));
      vt.push_back(mk(0, 1, 1, 0, 1, 4, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 1, 5, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 1, 6, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 1, 7, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 0, 7, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 0, 7, 1, 4, W1));
      // Grant dropped for 3 cycles after byte 1 issued.
      vt.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 0));
      vt.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
      vt.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
      vt.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 1, 2, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 1, 3, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 0, 3, 0, 0, 0));
      vt.push_back(mk(0, 1, 1, 0, 0, 3, 1, 0, W0));

      foreach (vt[i]) begin
         if (vt[i].rs) do_reset();
         cyc(vt[i].rdy, vt[i].gnt, vt[i].idr, 1'b0, 32'h0);
         chk($sformatf("tbl%0d_rd", i), {31'b0, mem_rd_o}, {31'b0, vt[i].erd});
         if (vt[i].erd) chk($sformatf("tbl%0d_a", i), mem_a_o, vt[i].ea);
         chk($sformatf("tbl%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, vt[i].ev});
         if (vt[i].ev) begin
            chk($sformatf("tbl%0d_pc", i), pc_o, vt[i].epc);
            chk($sformatf("tbl%0d_inst", i), inst_o, vt[i].einst);
         end
      end

      // Redirect after byte 2 issued: stale byte dropped, refetch from 0x1000.
      do_reset();
      repeat (3) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 1, 32'h0000_1003);
      chk("jmp_no_rd", {31'b0, mem_rd_o}, 32'd0);
      cyc(1, 1, 0, 0, 0);
      chk("jmp_rd", {31'b0, mem_rd_o}, 32'd1);
      chk("jmp_addr", mem_a_o, 32'h0000_1000);
      repeat (4) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk("jmp_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("jmp_pc", pc_o, 32'h0000_1000);
      chk("jmp_inst", inst_o, 32'hDEAD_BEEF);

      // PC wrap from 0xFFFF_FFFC to 0.
      do_reset();
      cyc(1, 1, 0, 1, 32'hFFFF_FFFF);
      chk("wrap_jmp_no_rd", {31'b0, mem_rd_o}, 32'd0);
      cyc(1, 1, 0, 0, 0);
      chk("wrap_addr0", mem_a_o, 32'hFFFF_FFFC);
      repeat (4) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk("wrap_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
      chk("wrap_inst", inst_o, ram_word(32'hFFFF_FFFC));
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk("wrap_next_rd", {31'b0, mem_rd_o}, 32'd1);
      chk("wrap_next_addr", mem_a_o, 32'h0);
      repeat (4) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk("wrap_next_pc", pc_o, 32'h0);
      chk("wrap_next_inst", inst_o, W0);

      // rdy_i low mid-fetch with byte 1 in flight, then frozen HOLD.
      do_reset();
      repeat (2) cyc(1, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("rdy_no_rd0", {31'b0, mem_rd_o}, 32'd0);
      cyc(0, 1, 0, 0, 0);
      chk("rdy_no_rd1", {31'b0, mem_rd_o}, 32'd0);
      cyc(1, 1, 0, 0, 0);
      chk("rdy_resume_addr", mem_a_o, 32'd2);
      repeat (2) cyc(1, 1, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      chk("rdy_inst", inst_o, W0);
      chk("rdy_valid", {31'b0, inst_valid_o}, 32'd1);
      cyc(0, 1, 1, 0, 0);
      chk("rdy_hold_frozen", {31'b0, inst_valid_o}, 32'd1);
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk("rdy_release_valid", {31'b0, inst_valid_o}, 32'd0);
      chk("rdy_release_addr", mem_a_o, 32'd4);

      // Jump and id_ready together in HOLD: the redirect wins.
      do_reset();
      repeat (5) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 1, 32'h0000_0040);
      cyc(1, 1, 0, 0, 0);
      chk("jh_valid_clr", {31'b0, inst_valid_o}, 32'd0);
      chk("jh_addr", mem_a_o, 32'h40);
      repeat (4) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0);
      chk("jh_pc", pc_o, 32'h40);
      chk("jh_inst", inst_o, ram_word(32'h40));

`ifdef IF_ICACHE_EN
      // Second pass over pc 0 must hit without touching memory.
      do_reset();
      repeat (5) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 1, 0, 0);
      cyc(1, 1, 0, 1, 32'h0);
      chk("ic_jmp_no_rd", {31'b0, mem_rd_o}, 32'd0);
      cyc(1, 1, 0, 0, 0);
      chk("ic_hit_no_rd", {31'b0, mem_rd_o}, 32'd0);
      cyc(1, 1, 0, 0, 0);
      chk("ic_hit_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("ic_hit_pc", pc_o, 32'h0);
      chk("ic_hit_inst", inst_o, W0);
`endif

      // Random stream: delivered (pc, inst) must follow the sequential/redirect program order.
      do_reset();
      exp_pc = 32'h0; prev_v = 1'b0; since = 0; delivered = 0; hpc = 0; hinst = 0;
      for (int i = 0; i < 3000; i++) begin
         r   = ($urandom_range(0, 9) != 0);
         g   = ($urandom_range(0, 3) != 0);
         idr = 1'($urandom_range(0, 1));
         j   = r && ($urandom_range(0, 39) == 0);
         ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom_range(0, 511));
         cyc(r, g, idr, j, ja);
         if (mem_rd_o) chk("rnd_rd_gated", {29'b0, rdy_i, mem_grant_i, !jump_i}, 32'd7);
         if (inst_valid_o && !prev_v) begin
            chk("rnd_pc", pc_o, exp_pc);
            chk("rnd_inst", inst_o, ram_word(exp_pc));
            delivered++;
            since = 0;
         end else if (inst_valid_o) begin
            chk("rnd_hold_pc", pc_o, hpc);
            chk("rnd_hold_inst", inst_o, hinst);
         end
         hpc = pc_o; hinst = inst_o; prev_v = inst_valid_o;
         if (j) exp_pc = ja & 32'hFFFF_FFFC;
         else if (inst_valid_o && idr && r) exp_pc = exp_pc + 32'd4;
         since++;
         if (since == 300) begin
            n_cmp++; n_bad++;
            $display("FAIL rnd_liveness: got no instruction in 300 cycles expected one");
            since = 0;
         end
      end
      chk("rnd_delivered_min", {31'b0, (delivered >= 50)}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
